// File: rtl/seq_mult_pkg.sv
// Shared constants and helpers for the seq_mult_32 shift-add multiplier:
// FSM state encoding, operand width, iteration count and sign helpers.
package seq_mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 32;
    localparam int CNT_W      = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Magnitude of a two's-complement operand; -2^31 maps to 2^31, which still fits unsigned.
    function automatic logic [MULT_WIDTH-1:0] magnitude(input logic [MULT_WIDTH-1:0] v,
                                                        input logic take_abs);
        return (take_abs && v[MULT_WIDTH-1]) ? ((~v) + MULT_WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*MULT_WIDTH-1:0] negate2w(input logic [2*MULT_WIDTH-1:0] v);
        return (~v) + (2*MULT_WIDTH)'(1);
    endfunction

endpackage

// File: rtl/seq_mult_32_cla.sv
// 32-bit carry-lookahead adder: 4-bit ripple groups, group carries formed
// from group generate/propagate terms.
module seq_mult_32_cla (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);

    logic [31:0] g;
    logic [31:0] p;

    assign g = X & Y;
    assign p = X ^ Y;

    always_comb begin
        logic c_grp;
        logic c_bit;
        logic grp_g;
        logic grp_p;
        S     = '0;
        c_grp = Cin;
        for (int k = 0; k < 8; k++) begin
            c_bit = c_grp;
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = 0; j < 4; j++) begin
                S[4*k+j] = p[4*k+j] ^ c_bit;
                c_bit    = g[4*k+j] | (p[4*k+j] & c_bit);
                grp_g    = g[4*k+j] | (p[4*k+j] & grp_g);
                grp_p    = grp_p & p[4*k+j];
            end
            c_grp = grp_g | (grp_p & c_grp);
        end
        Cout = c_grp;
    end

endmodule

// File: rtl/seq_mult_32.sv
// Multi-cycle 32x32->64 shift-add multiplier with start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the is_signed port and sign correction in FIX.
module seq_mult_32 #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import seq_mult_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             sign_q, sign_d;

    logic             take_abs;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SEQ_MULT_SIGNED_EN
    assign take_abs = is_signed;
`else
    assign take_abs = 1'b0;
`endif

    assign addend = lo_q[0] ? mcand_q : '0;

    seq_mult_32_cla u_cla (
        .X    (hi_q),
        .Y    (addend),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        sign_d  = sign_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d = magnitude(a, take_abs);
                    hi_d    = '0;
                    lo_d    = magnitude(b, take_abs);
                    sign_d  = take_abs & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Carry-out becomes the new hi MSB, so no partial-product bit is lost.
                hi_d  = {cout, sum[WIDTH-1:1]};
                lo_d  = {sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (sign_q) begin
                    {hi_d, lo_d} = negate2w({hi_q, lo_q});
                end
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            sign_q  <= sign_d;
        end
    end

    assign ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy    = (state_q == ST_RUN)  || (state_q == ST_FIX);
    assign done    = (state_q == ST_DONE);
    assign product = {hi_q, lo_q};

endmodule
